fpu_issue_stage: RTL and testbench
==================================

FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 The module SHALL be clocked by a single clock, with reset synchronous and active-high: one clock (clk) and one synchronous active-high reset (reset).
REQ-002 The module SHALL have parameter DEPTH, default 4: operand queue entries (power of two, >=2).
REQ-003 The module SHALL have parameter TAG_W, default 5: destination tag width.
REQ-004 The module SHALL have parameter DIV_CYCLES, default 4: cycles FDIV occupies the ALU (>=1).
REQ-005 The module SHALL have port clk  in  1  rising-edge clock.
REQ-006 The module SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 The module SHALL have ports in_valid  in  1, and in_ready  out  1: upstream handshake.
REQ-008 The module SHALL have ports in_instr  in  alu_instruction_t, in_op1  in  32, in_op2  in  32, and in_tag  in  TAG_W: op, operand bit patterns, and destination.
REQ-009 The module SHALL have ports alu_instr  out  alu_instruction_t, alu_op1  out  32, and alu_op2  out  32: drive the combinational floating ALU.
REQ-010 The module SHALL have port alu_result  in  32: combinational ALU result.
REQ-011 The module SHALL have ports out_valid  out  1, out_ready  in  1, out_result  out  32, and out_tag  out  TAG_W: writeback handshake.
REQ-012 The module SHALL have ports count  out  $clog2(DEPTH+1) (queued entries) and busy  out  1 (count!=0 or out_valid).

Function
REQ-013 The queue SHALL be a circular FIFO; a push occurs on an edge where in_valid && in_ready, and a pop on the capture edge.
REQ-014 Pointers SHALL wrap modulo DEPTH.
REQ-015 in_ready SHALL equal (count < DEPTH) && !reset, with no same-cycle pop bypass.
REQ-016 alu_instr, alu_op1, and alu_op2 SHALL continuously present the head slot; their contents SHALL be don't-care when count==0.
REQ-017 The head operands SHALL remain stable from the cycle the head becomes valid until its pop.
REQ-018 The output slot is free when !out_valid || out_ready.
REQ-019 FSM states SHALL be IDLE and DIV_WAIT.
REQ-020 IDLE, count>0, head != FDIV, slot free: on that edge the block SHALL capture alu_result into out_result and head tag into out_tag, set out_valid=1, and pop; the state SHALL remain IDLE.
REQ-021 IDLE, count>0, head != FDIV, slot not free: the block SHALL hold with no pop.
REQ-022 IDLE, count>0, head == FDIV: if DIV_CYCLES==1, the block SHALL behave per REQ-020; otherwise it SHALL load div_cnt=DIV_CYCLES-2 and go to DIV_WAIT.
REQ-023 DIV_WAIT, div_cnt>0: div_cnt SHALL decrement each cycle, independent of out_ready.
REQ-024 DIV_WAIT, div_cnt==0, slot free: the block SHALL capture and pop per REQ-020, then go to IDLE.
REQ-025 DIV_WAIT, div_cnt==0, slot not free: the block SHALL hold in DIV_WAIT.
REQ-026 Latency for a non-FDIV op pushed at edge E into an empty idle block with a free slot: out_valid SHALL be 1 after edge E+1.
REQ-027 Latency for FDIV under the same conditions: out_valid SHALL be 1 after edge E+DIV_CYCLES.
REQ-028 Throughput SHALL be one non-FDIV result per cycle when out_ready is held high.
REQ-029 out_valid SHALL clear on an accept edge (out_valid && out_ready) with no new capture.
REQ-030 A new capture on the same edge as an accept SHALL keep out_valid at 1.
REQ-031 While out_valid && !out_ready, out_result and out_tag SHALL be held stable.
REQ-032 Results SHALL be delivered strictly in push order.
REQ-033 A push and pop on the same edge SHALL leave count unchanged.
REQ-034 A push into an empty queue SHALL NOT be captured on that same edge.
REQ-035 count SHALL never exceed DEPTH or underflow.

Reset
REQ-036 Reset SHALL set count, pointers, div_cnt, out_result, out_tag, and out_valid to 0, and the state to IDLE.
REQ-037 Reset SHALL have priority over push, pop, and capture.
REQ-038 Reset during DIV_WAIT SHALL discard the in-flight FDIV and all queued entries, with no result emitted afterwards.
REQ-039 in_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.

Verification
REQ-040 FADD 0x3F800000,0x40000000 tag 3, out_ready=1 -> out_valid one cycle after push edge, out_result 0x40400000, out_tag 3.
REQ-041 Four back-to-back FMUL (2.0*3.0, tags 0..3), out_ready=1 -> four consecutive out_valid cycles, 0x40C00000 each, tags 0,1,2,3.
REQ-042 FDIV 0x40C00000/0x40000000 then FADD, DIV_CYCLES=4 -> 0x40400000 appears DIV_CYCLES cycles after push, FADD result the following cycle, ALU inputs stable throughout.
REQ-043 out_ready=0, offer six ops, DEPTH=4 -> five accepted (one in the output register, four queued), in_ready=0, count=4, sixth stalled; raise out_ready -> all six emitted in order.
REQ-044 Assert reset during DIV_WAIT with two queued ops -> next cycle out_valid=0, count=0, busy=0, no later outputs; new op after reset completes normally.
REQ-045 Twenty ops, random out_ready/in_valid, DEPTH=4 -> pointer wrap exercised, results and tags match an in-order reference model, count never exceeds 4.

Source files
------------

// File: rtl/fpu_issue_stage.sv
// Purpose : queues FP operations, presents the oldest to an external combinational
//           ALU, and registers its result into a single valid/ready output slot.
// Latency : 1 cycle from push to out_valid for non-FDIV ops; DIV_CYCLES for FDIV.
// Backpressure: in_ready drops when the queue is full; a full output slot stalls
//           the head.
// Ports   : clk/reset; in_* push side (valid/ready); alu_* drive the external ALU
//           with the head slot; alu_result returns its combinational result;
//           out_* writeback side (valid/ready); count = queued entries;
//           busy = anything queued or pending.

package fpu_issue_pkg;
    typedef enum logic [2:0] {
        ALU_FADD  = 3'd0,
        ALU_FSUB  = 3'd1,
        ALU_FMUL  = 3'd2,
        ALU_FDIV  = 3'd3,
        ALU_FMIN  = 3'd4,
        ALU_FMAX  = 3'd5,
        ALU_FSGNJ = 3'd6,
        ALU_FCVT  = 3'd7
    } alu_instruction_t;
endpackage

module fpu_issue_stage
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 5,
    parameter int DIV_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  alu_instruction_t           in_instr,
    input  logic [31:0]                in_op1,
    input  logic [31:0]                in_op2,
    input  logic [TAG_W-1:0]           in_tag,
    output alu_instruction_t           alu_instr,
    output logic [31:0]                alu_op1,
    output logic [31:0]                alu_op2,
    input  logic [31:0]                alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W  = $clog2(DEPTH + 1);
    // div_cnt only ever holds values up to DIV_CYCLES-2
    localparam int DCNT_W   = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
    localparam int DIV_LOAD = (DIV_CYCLES >= 2) ? DIV_CYCLES - 2 : 0;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_DIV_WAIT = 1'b1;

    typedef struct packed {
        alu_instruction_t  instr;
        logic [31:0]       op1;
        logic [31:0]       op2;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [0:0]           state_q, state_d;
    logic [DCNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_result_q, out_result_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;

    entry_t               head;
    logic                 push;
    logic                 pop;
    logic                 slot_free;

    // No pop bypass: a full queue refuses a push even if the head leaves this edge.
    assign in_ready  = (count_q < COUNT_W'(DEPTH)) && !reset;
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid_q || out_ready;

    // The head slot is never the write target while occupied, so these stay
    // stable from the moment the head becomes valid until its pop.
    assign head      = mem_q[rd_ptr_q];
    assign alu_instr = head.instr;
    assign alu_op1   = head.op1;
    assign alu_op2   = head.op2;

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign count      = count_q;
    assign busy       = (count_q != '0) || out_valid_q;

    // Issue control: decides pop/capture and the FDIV occupancy wait.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        pop          = 1'b0;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    if ((head.instr == ALU_FDIV) && (DIV_CYCLES > 1)) begin
                        // The entry edge counts as the first divide cycle and
                        // the capture edge as the last.
                        state_d   = ST_DIV_WAIT;
                        div_cnt_d = DCNT_W'(DIV_LOAD);
                    end else if (slot_free) begin
                        pop = 1'b1;
                    end
                end
            end
            ST_DIV_WAIT: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else if (slot_free) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_tag_d    = head.tag;
        end
    end

    // Queue pointers, occupancy and storage
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{instr: in_instr, op1: in_op1, op2: in_op2, tag: in_tag};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    // Payload storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Purpose : self-checking bench for fpu_issue_stage with a table-driven ALU model.
// Latency : checks 1-cycle issue and DIV_CYCLES FDIV latency.
// Backpressure: exercises full queue, held output and random ready/valid.

module tb_fpu_issue_stage;
    import fpu_issue_pkg::*;

    localparam int DEPTH      = 4;
    localparam int TAG_W      = 5;
    localparam int DIV_CYCLES = 4;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    alu_instruction_t     in_instr;
    logic [31:0]          in_op1;
    logic [31:0]          in_op2;
    logic [TAG_W-1:0]     in_tag;
    alu_instruction_t     alu_instr;
    logic [31:0]          alu_op1;
    logic [31:0]          alu_op2;
    logic [31:0]          alu_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic [TAG_W-1:0]     out_tag;
    logic [2:0]           count;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    fpu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
        .alu_instr(alu_instr), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: exact IEEE results for the directed vectors, an arbitrary
    // but deterministic mix of the operands for everything else.
    function automatic logic [31:0] alu_model(alu_instruction_t op, logic [31:0] a, logic [31:0] b);
        if (op == ALU_FADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == ALU_FMUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        if (op == ALU_FDIV && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
    endfunction

    assign alu_result = alu_model(alu_instr, alu_op1, alu_op2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input alu_instruction_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_instr = op;
        in_op1   = a;
        in_op2   = b;
        in_tag   = t;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = ALU_FADD;
        in_op1    = '0;
        in_op2    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (out_result !== 32'd0 || out_tag !== 5'd0) begin
            errors++; $display("FAIL reset_out_regs: got %h/%0d expected 0/0", out_result, out_tag);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_fadd();
        out_ready = 1'b1;
        drive_op(ALU_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd3);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            errors++; $display("FAIL fadd_push_edge: got valid %b count %0d expected 0/1", out_valid, count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL fadd_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_result !== 32'h4040_0000) begin
            errors++; $display("FAIL fadd_result: got %h expected 40400000", out_result);
        end
        checks++;
        if (out_tag !== 5'd3) begin errors++; $display("FAIL fadd_tag: got %0d expected 3", out_tag); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fadd_drain: got valid %b busy %b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_op(ALU_FMUL, 32'h4000_0000, 32'h4040_0000, 5'(i));
            else       in_valid = 1'b0;
            tick();
            if (i >= 1 && i <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== 32'h40C0_0000 || out_tag !== 5'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got v%b %h tag %0d expected v1 40c00000 tag %0d",
                             i, out_valid, out_result, out_tag, i - 1);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle%0d: got valid %b expected 0", i, out_valid);
                end
            end
        end
    endtask

    task automatic test_fdiv();
        out_ready = 1'b1;
        drive_op(ALU_FDIV, 32'h40C0_0000, 32'h4000_0000, 5'd7);
        tick();
        for (int k = 0; k < DIV_CYCLES; k++) begin
            if (k == 0)      drive_op(ALU_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd8);
            else if (k == 1) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL fdiv_early_valid%0d: got %b expected 0", k, out_valid);
            end
            checks++;
            if (alu_instr !== ALU_FDIV || alu_op1 !== 32'h40C0_0000 || alu_op2 !== 32'h4000_0000) begin
                errors++;
                $display("FAIL fdiv_alu_stable%0d: got %0d %h %h expected 3 40c00000 40000000",
                         k, alu_instr, alu_op1, alu_op2);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_tag !== 5'd7) begin
            errors++;
            $display("FAIL fdiv_result: got v%b %h tag %0d expected v1 40400000 tag 7", out_valid, out_result, out_tag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_tag !== 5'd8) begin
            errors++;
            $display("FAIL fdiv_follow_fadd: got v%b %h tag %0d expected v1 40400000 tag 8", out_valid, out_result, out_tag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fdiv_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        alu_instruction_t bp_op [6];
        logic [31:0]      bp_a  [6];
        logic [31:0]      bp_b  [6];
        int               nrecv;
        int               cyc;
        logic             acc;
        bp_op[0] = ALU_FADD; bp_a[0] = 32'h1111_0000; bp_b[0] = 32'h0000_2222;
        bp_op[1] = ALU_FSUB; bp_a[1] = 32'h3333_4444; bp_b[1] = 32'h5555_6666;
        bp_op[2] = ALU_FMUL; bp_a[2] = 32'h7777_8888; bp_b[2] = 32'h9999_AAAA;
        bp_op[3] = ALU_FMIN; bp_a[3] = 32'hBBBB_CCCC; bp_b[3] = 32'hDDDD_EEEE;
        bp_op[4] = ALU_FMAX; bp_a[4] = 32'h0123_4567; bp_b[4] = 32'h89AB_CDEF;
        bp_op[5] = ALU_FSUB; bp_a[5] = 32'hFEDC_BA98; bp_b[5] = 32'h7654_3210;

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_op(bp_op[i], bp_a[i], bp_b[i], 5'(10 + i));
            tick();
        end
        drive_op(bp_op[5], bp_a[5], bp_b[5], 5'd15);
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", count); end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_result !== alu_model(bp_op[0], bp_a[0], bp_b[0])) begin
            errors++; $display("FAIL bp_held_output: got v%b tag %0d %h expected v1 tag 10", out_valid, out_tag, out_result);
        end

        out_ready = 1'b1;
        nrecv = 0;
        cyc   = 0;
        while (nrecv < 6 && cyc < 40) begin
            if (out_valid) begin
                checks++;
                if (out_tag !== 5'(10 + nrecv) || out_result !== alu_model(bp_op[nrecv], bp_a[nrecv], bp_b[nrecv])) begin
                    errors++;
                    $display("FAIL bp_order%0d: got tag %0d %h expected tag %0d %h", nrecv, out_tag, out_result,
                             10 + nrecv, alu_model(bp_op[nrecv], bp_a[nrecv], bp_b[nrecv]));
                end
                nrecv++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (nrecv != 6) begin errors++; $display("FAIL bp_drain_count: got %0d expected 6", nrecv); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_div();
        out_ready = 1'b1;
        drive_op(ALU_FDIV, 32'h40C0_0000, 32'h4000_0000, 5'd20);
        tick();
        drive_op(ALU_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd21);
        tick();
        drive_op(ALU_FMUL, 32'h4000_0000, 32'h4040_0000, 5'd22);
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rdiv_pre: got count %0d valid %b expected 3/0", count, out_valid);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rdiv_cleared: got v%b count %0d busy %b rdy %b expected 0/0/0/0", out_valid, count, busy, in_ready);
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rdiv_ghost%0d: got valid %b expected 0", k, out_valid); end
        end
        drive_op(ALU_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_tag !== 5'd9) begin
            errors++;
            $display("FAIL rdiv_after: got v%b %h tag %0d expected v1 40400000 tag 9", out_valid, out_result, out_tag);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0]      exp_res [$];
        logic [TAG_W-1:0] exp_tag [$];
        int               sent;
        int               recv;
        int               cyc;
        alu_instruction_t op;
        logic [31:0]      a;
        logic [31:0]      b;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 20 && cyc < 600) begin
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       op = ALU_FADD;
                    1:       op = ALU_FSUB;
                    2:       op = ALU_FMUL;
                    3:       op = ALU_FDIV;
                    default: op = ALU_FMAX;
                endcase
                a = $urandom;
                b = $urandom;
                drive_op(op, a, b, 5'(sent));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_res.push_back(alu_model(in_instr, in_op1, in_op2));
                exp_tag.push_back(in_tag);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_res.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got tag %0d %h expected nothing", out_tag, out_result);
                end else if (out_result !== exp_res[0] || out_tag !== exp_tag[0]) begin
                    errors++;
                    $display("FAIL rand_result%0d: got tag %0d %h expected tag %0d %h", recv, out_tag, out_result,
                             exp_tag[0], exp_res[0]);
                end
                if (exp_res.size() != 0) begin
                    void'(exp_res.pop_front());
                    void'(exp_tag.pop_front());
                end
                recv++;
            end
            checks++;
            if (count > 3'(DEPTH)) begin errors++; $display("FAIL rand_count: got %0d expected <= %0d", count, DEPTH); end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 20) begin errors++; $display("FAIL rand_complete: got %0d results expected 20", recv); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_back_to_back();
        test_fdiv();
        test_backpressure();
        test_reset_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
